// File: rtl/usb_pkg.sv
// usb_pkg: shared USB receive/transmit state encodings, handshake codes and CRC16 constants
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_DROP,
        ST_CHECK,
        ST_HSK
    } rcv_state_t;

    localparam logic [1:0] HSK_NONE = 2'b00;
    localparam logic [1:0] HSK_ACK  = 2'b01;
    localparam logic [1:0] HSK_NAK  = 2'b10;

    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_REF = 16'hA001;
    localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

endpackage

// File: rtl/usb_crc16_byte.sv
// usb_crc16_byte: combinational byte-wide USB CRC16 update, byte shifted in LSB first
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    // one reflected-polynomial step per data bit, LSB first as on the wire
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++)
            crc_out = (crc_out[0] ^ data[i]) ? ((crc_out >> 1) ^ CRC16_POLY_REF) : (crc_out >> 1);
    end

endmodule

// File: rtl/usb_rcv_ctrl.sv
// usb_rcv_ctrl: OUT/SETUP data-stage receive controller; writes payload to the FIFO,
// checks CRC16, length and DATA0/DATA1 toggle, then issues the handshake and flushes
// rejected payloads. Define USB_RCV_TOGGLE_EN to enable data toggle tracking.
module usb_rcv_ctrl
    import usb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_PKT    = 8
) (
    input  logic       clk,
    input  logic       rst0_async,
    input  logic       pkt_start,
    input  logic       pkt_pid_odd,
    input  logic       ep_en,
    input  logic       toggle_clr,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_eop,
    input  logic       rx_err,
    output logic       fifo_wr_en,
    output logic [7:0] fifo_wr_data,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    output logic       fifo_rst0_sync,
    output logic       hsk_req,
    output logic [1:0] hsk_code,
    output logic       trsac_ok,
    output logic [6:0] byte_cnt,
    output logic       toggle
);

    localparam logic [7:0] CNT_MAX = 8'(MAX_PKT + 2);

    rcv_state_t  state, state_nx;
    logic [15:0] crc, crc_nx;
    logic [7:0]  cnt, cnt_inc;
    logic        nak, err, ovf_now, wr, match, commit;
    logic [1:0]  code;
    logic        unused_cfg;

    assign unused_cfg = ^ADDR_WIDTH;

    usb_crc16_byte u_crc (
        .crc_in (crc),
        .data   (rx_data),
        .crc_out(crc_nx)
    );

    // counter includes the two CRC bytes and saturates rather than wrapping
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign ovf_now = rx_valid && (fifo_full || cnt_inc > CNT_MAX);
    assign wr      = state == ST_RECV && rx_valid && !fifo_full;

    // state register
    always_ff @(posedge clk or negedge rst0_async)
        if (!rst0_async) state <= ST_IDLE;
        else state <= state_nx;

    // next-state: a byte arriving with rx_eop is processed before the end of packet
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (pkt_start) state_nx = (ep_en && fifo_empty) ? ST_RECV : ST_DROP;
            ST_RECV:  state_nx = rx_eop ? ST_CHECK : ovf_now ? ST_DROP : ST_RECV;
            ST_DROP:  if (rx_eop) state_nx = ST_CHECK;
            ST_CHECK: state_nx = ST_HSK;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // decision: errors and bad CRC stay silent, a pending NAK beats an ACK,
    // and only an in-sequence ACK commits the payload
    always_comb begin
        code   = err ? HSK_NONE : nak ? HSK_NAK :
                 (crc != CRC16_RESIDUAL || cnt < 8'd2) ? HSK_NONE : HSK_ACK;
        commit = state == ST_CHECK && code == HSK_ACK && match;
    end

    // running CRC, byte counter and reject flags for the packet in flight
    always_ff @(posedge clk or negedge rst0_async)
        if (!rst0_async) begin
            crc <= CRC16_INIT;
            cnt <= 8'd0;
            nak <= 1'b0;
            err <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (pkt_start) begin
                crc <= CRC16_INIT;
                cnt <= 8'd0;
                err <= 1'b0;
                nak <= !(ep_en && fifo_empty);
            end
        end else begin
            if (state == ST_RECV && rx_valid) begin
                crc <= crc_nx;
                cnt <= cnt_inc;
                if (ovf_now) nak <= 1'b1;
            end
            if ((state == ST_RECV || state == ST_DROP) && rx_err) err <= 1'b1;
        end

    // registered FIFO write port and handshake outputs; flush lands in the HSK cycle
    always_ff @(posedge clk or negedge rst0_async)
        if (!rst0_async) begin
            fifo_wr_en     <= 1'b0;
            fifo_wr_data   <= 8'h00;
            fifo_rst0_sync <= 1'b1;
            hsk_req        <= 1'b0;
            hsk_code       <= HSK_NONE;
            trsac_ok       <= 1'b0;
            byte_cnt       <= 7'd0;
        end else begin
            fifo_wr_en     <= wr;
            if (wr) fifo_wr_data <= rx_data;
            hsk_req        <= state == ST_CHECK;
            trsac_ok       <= commit;
            fifo_rst0_sync <= !(state == ST_CHECK && !commit);
            if (state == ST_CHECK) hsk_code <= code;
            if (commit) byte_cnt <= 7'(cnt - 8'd2);
        end

`ifdef USB_RCV_TOGGLE_EN
    logic pid;

    assign match = pid == toggle;

    // capture the packet's data PID and advance the expected toggle on commit; clear wins
    always_ff @(posedge clk or negedge rst0_async)
        if (!rst0_async) begin
            pid    <= 1'b0;
            toggle <= 1'b0;
        end else begin
            if (state == ST_IDLE && pkt_start) pid <= pkt_pid_odd;
            toggle <= toggle_clr ? 1'b0 : commit ? ~toggle : toggle;
        end
`else
    logic unused_toggle_in;

    assign unused_toggle_in = pkt_pid_odd ^ toggle_clr;
    assign match            = 1'b1;
    assign toggle           = 1'b0;
`endif

endmodule
